// File: rtl/key_bank.sv
// rtl/key_bank.sv - multi-slot key store with word-serial load, atomic commit and per-slot sticky locks
module key_bank #(
  parameter  int KEY_W     = 128,
  parameter  int BUS_W     = 32,
  parameter  int NUM_SLOTS = 4,
  localparam int WORDS     = KEY_W / BUS_W,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              clear_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [SLOT_W-1:0] wr_slot_i,
  input  logic [BUS_W-1:0]  wr_data_i,
  input  logic              abort_i,
  input  logic              lock_i,
  input  logic [SLOT_W-1:0] lock_slot_i,
  input  logic [SLOT_W-1:0] rd_slot_i,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_valid_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t                state_q, state_d;
  logic [KEY_W-1:0]      shadow_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [SLOT_W-1:0]     target_q;
  logic [KEY_W-1:0]      slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  valid_q;
  logic [NUM_SLOTS-1:0]  lock_q;

  assign wr_ready_o = (state_q != COMMIT);
  assign busy_o     = (state_q != IDLE);
  // Lock is sampled in COMMIT so a lock landing mid-load still blocks that load.
  assign err_o      = (state_q == COMMIT) && lock_q[target_q];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_valid_i) state_d = (WORDS == 1) ? COMMIT : LOAD;
      LOAD: begin
        if (abort_i)                          state_d = IDLE;
        else if (wr_valid_i && cnt_q == LAST) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shadow_q    <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      valid_q     <= '0;
      lock_q      <= '0;
      key_o       <= '0;
      key_valid_o <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= '0;
    end else if (clear_i) begin
      shadow_q    <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      valid_q     <= '0;
      lock_q      <= '0;
      key_o       <= '0;
      key_valid_o <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= '0;
    end else begin
      if (lock_i) lock_q[lock_slot_i] <= 1'b1;

      key_o       <= valid_q[rd_slot_i] ? slot_q[rd_slot_i] : '0;
      key_valid_o <= valid_q[rd_slot_i];

      case (state_q)
        IDLE: begin
          if (wr_valid_i) begin
            target_q                    <= wr_slot_i;
            shadow_q[KEY_W-1 -: BUS_W]  <= wr_data_i;
            cnt_q                       <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (abort_i) begin
            shadow_q <= '0;
            cnt_q    <= '0;
          end else if (wr_valid_i) begin
            for (int w = 0; w < WORDS; w++)
              if (cnt_q == CNT_W'(w)) shadow_q[KEY_W-1-w*BUS_W -: BUS_W] <= wr_data_i;
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        COMMIT: begin
          if (!lock_q[target_q]) begin
            slot_q[target_q]  <= shadow_q;
            valid_q[target_q] <= 1'b1;
          end
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_bank.sv
// tb/tb_key_bank.sv - randomized self-checking bench for key_bank against a slot/lock array model
module tb_key_bank;

  logic         clock_i = 1'b0;
  logic         reset_ni = 1'b0;
  logic         clear_i = 1'b0;
  logic         wr_valid_i = 1'b0;
  logic         wr_ready_o;
  logic [1:0]   wr_slot_i = '0;
  logic [31:0]  wr_data_i = '0;
  logic         abort_i = 1'b0;
  logic         lock_i = 1'b0;
  logic [1:0]   lock_slot_i = '0;
  logic [1:0]   rd_slot_i = '0;
  logic [127:0] key_o;
  logic         key_valid_o;
  logic         busy_o;
  logic         err_o;

  int vectors = 0;
  int errors  = 0;

  logic [127:0] ref_slot  [4];
  bit           ref_valid [4];
  bit           ref_lock  [4];

  key_bank dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .clear_i(clear_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_slot_i(wr_slot_i),
    .wr_data_i(wr_data_i), .abort_i(abort_i), .lock_i(lock_i),
    .lock_slot_i(lock_slot_i), .rd_slot_i(rd_slot_i), .key_o(key_o),
    .key_valid_o(key_valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int s = 0; s < 4; s++) begin
      ref_slot[s]  = '0;
      ref_valid[s] = 1'b0;
      ref_lock[s]  = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int s = 0; s < 4; s++) begin
      rd_slot_i = s[1:0];
      tick();
      check($sformatf("key_slot%0d", s), key_o, ref_valid[s] ? ref_slot[s] : 128'h0);
      check($sformatf("valid_slot%0d", s), key_valid_o, ref_valid[s]);
    end
  endtask

  task automatic do_lock(input int s);
    lock_i = 1'b1;
    lock_slot_i = s[1:0];
    tick();
    lock_i = 1'b0;
    ref_lock[s] = 1'b1;
  endtask

  // Beats go out MSW first; later beats carry a random wr_slot_i since only the first is sampled.
  task automatic load_key(input int s, input logic [127:0] key, input int gap2, input bit rnd_gaps,
                          input int lock_beat, input int abort_beat, input bit clear_commit);
    int g;
    for (int b = 0; b < 4; b++) begin
      g = (b == 2) ? gap2 : 0;
      if (rnd_gaps) g += $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        wr_valid_i = 1'b0;
        wr_data_i  = $urandom;
        tick();
        if (b > 0) check("busy_gap", busy_o, 1'b1);
      end
      wr_valid_i = 1'b1;
      wr_slot_i  = (b == 0) ? s[1:0] : 2'($urandom);
      wr_data_i  = key[127-32*b -: 32];
      if (b == abort_beat) abort_i = 1'b1;
      if (b == lock_beat) begin
        lock_i = 1'b1;
        lock_slot_i = s[1:0];
      end
      tick();
      wr_valid_i = 1'b0;
      abort_i    = 1'b0;
      if (b == lock_beat) begin
        lock_i = 1'b0;
        ref_lock[s] = 1'b1;
      end
      if (b == abort_beat) begin
        check("abort_to_idle", busy_o, 1'b0);
        return;
      end
    end
    check("commit_ready", wr_ready_o, 1'b0);
    check("commit_busy", busy_o, 1'b1);
    check("commit_err", err_o, ref_lock[s]);
    if (clear_commit) clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    if (clear_commit) model_zero();
    else if (!ref_lock[s]) begin
      ref_slot[s]  = key;
      ref_valid[s] = 1'b1;
    end
    check("post_busy", busy_o, 1'b0);
    check("post_err", err_o, 1'b0);
    check("post_ready", wr_ready_o, 1'b1);
  endtask

  initial begin
    logic [127:0] k;
    int s;
    int ab;
    int lk;
    model_zero();

    #2;
    check("rst_key", key_o, 128'h0);
    check("rst_valid", key_valid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ready", wr_ready_o, 1'b1);
    tick();
    reset_ni = 1'b1;
    tick();

    k = 128'h00112233445566778899AABBCCDDEEFF;
    load_key(2, k, 0, 1'b0, -1, -1, 1'b0);
    check_all();

    load_key(2, ~k, 0, 1'b0, -1, -1, 1'b0);
    load_key(2, k, 3, 1'b0, -1, -1, 1'b0);
    check_all();

    load_key(1, {16{8'hA5}}, 0, 1'b0, -1, -1, 1'b0);
    load_key(1, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 2, -1, 1'b0);
    check_all();

    load_key(0, {4{32'hDEADBEEF}}, 0, 1'b0, -1, 2, 1'b0);
    load_key(0, 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 1'b0, -1, -1, 1'b0);
    check_all();

    do_lock(3);
    do_lock(3);
    load_key(3, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, -1, -1, 1'b0);
    check_all();

    for (int it = 0; it < 20; it++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      s  = $urandom_range(0, 2);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : -1;
      lk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      load_key(s, k, 0, 1'b1, lk, ab, 1'b0);
      check_all();
    end

    load_key(0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, -1, -1, 1'b1);
    check_all();
    load_key(3, 128'hCAFE, 0, 1'b0, -1, -1, 1'b0);
    check_all();

    wr_valid_i = 1'b1;
    wr_slot_i  = 2'd1;
    wr_data_i  = 32'h11111111;
    tick();
    wr_data_i  = 32'h22222222;
    tick();
    wr_valid_i = 1'b0;
    do_lock(2);
    reset_ni = 1'b0;
    #1;
    model_zero();
    check("rstmid_busy", busy_o, 1'b0);
    check("rstmid_ready", wr_ready_o, 1'b1);
    check("rstmid_key", key_o, 128'h0);
    check("rstmid_valid", key_valid_o, 1'b0);
    tick();
    reset_ni = 1'b1;
    tick();
    check_all();
    load_key(2, 128'hBEEF, 0, 1'b0, -1, -1, 1'b0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/key_bank.md
KEY_BANK -- requirements
Module: key_bank

Interface
REQ-001 Parameter KEY_W, default 128, key width in bits.
REQ-002 Parameter BUS_W, default 32, load-bus width in bits; KEY_W SHALL be an integer multiple of BUS_W; WORDS = KEY_W/BUS_W.
REQ-003 Parameter NUM_SLOTS, default 4, number of key slots (>=2); SLOT_W = clog2(NUM_SLOTS).
REQ-004 Design SHALL use one clock, clock_i; reset_ni is asynchronous and active-low.
REQ-005 clock_i  in  1  rising-edge clock.
REQ-006 reset_ni  in  1  asynchronous active-low reset.
REQ-007 clear_i  in  1  synchronous zeroize of all state.
REQ-008 wr_valid_i  in  1  load word valid.
REQ-009 wr_ready_o  out  1  load word ready.
REQ-010 wr_slot_i  in  SLOT_W  target slot, sampled on the first beat only.
REQ-011 wr_data_i  in  BUS_W  key word, most significant word first.
REQ-012 abort_i  in  1  discard the load in progress.
REQ-013 lock_i  in  1  one-cycle pulse; sets the lock on slot lock_slot_i.
REQ-014 lock_slot_i  in  SLOT_W  slot to lock.
REQ-015 rd_slot_i  in  SLOT_W  read slot select.
REQ-016 key_o  out  KEY_W  registered key of the read slot.
REQ-017 key_valid_o  out  1  registered valid flag of the read slot.
REQ-018 busy_o  out  1  high in LOAD or COMMIT.
REQ-019 err_o  out  1  one-cycle pulse on a rejected commit.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD and COMMIT.
REQ-021 A beat SHALL be accepted when wr_valid_i && wr_ready_o at a clock edge.
REQ-022 wr_ready_o SHALL be 1 in IDLE and LOAD, and 0 in COMMIT.
REQ-023 A beat accepted in IDLE SHALL:
- capture wr_slot_i;
- write wr_data_i into shadow bits [KEY_W-1 -: BUS_W];
- set the word counter to 1;
- move the FSM to LOAD (or straight to COMMIT if WORDS==1).
REQ-024 In LOAD, accepted beat k (0-based) SHALL fill shadow word k from the MSW end and increment the counter; the beat with k==WORDS-1 SHALL move the FSM to COMMIT.
REQ-025 Beats with wr_valid_i low SHALL leave the shadow and counter unchanged; gaps are unlimited.
REQ-026 COMMIT SHALL last exactly one cycle, then return to IDLE.
REQ-027 In COMMIT, if the target slot is unlocked, the shadow SHALL be copied atomically to the slot and its valid bit set.
REQ-028 In COMMIT, if the target slot is locked, the slot SHALL be unchanged and err_o SHALL pulse for that cycle.
REQ-029 A slot SHALL never hold a partially loaded key.
REQ-030 Lock status SHALL be evaluated in COMMIT, so a lock applied mid-load blocks that load.
REQ-031 abort_i in LOAD SHALL zero the shadow and counter, return the FSM to IDLE next cycle, and discard any beat presented that cycle.
REQ-032 abort_i in IDLE or COMMIT SHALL be ignored; a COMMIT in progress completes.
REQ-033 lock_i SHALL set lock[lock_slot_i] at the next edge; locks are sticky until clear_i or reset.
REQ-034 Locking a slot that is already locked SHALL have no effect.
REQ-035 key_o and key_valid_o SHALL register slot[rd_slot_i] and valid[rd_slot_i] every cycle, giving 1-cycle read latency.
REQ-036 key_o SHALL be 0 whenever the selected slot is invalid.
REQ-037 A commit at edge N SHALL be visible on key_o after edge N+1 when rd_slot_i selects that slot.
REQ-038 clear_i SHALL take priority over all other inputs and, at the next edge, zero:
- all slots, valid bits and locks;
- the shadow and counter;
- key_o, key_valid_o and err_o.
The FSM SHALL go to IDLE, and any beat presented that cycle SHALL be dropped.
REQ-039 busy_o SHALL be 1 exactly when the FSM is in LOAD or COMMIT.
REQ-040 The word counter SHALL never exceed WORDS-1 in LOAD and SHALL NOT wrap.

Reset
REQ-041 With reset_ni low, all state SHALL be zero:
- slots, valid bits, locks, shadow and counter;
- key_o=0, key_valid_o=0, err_o=0, busy_o=0;
- FSM in IDLE, wr_ready_o=1.
REQ-042 Reset assertion SHALL take effect immediately, including mid-load, and no partial key SHALL survive it.
REQ-043 Release SHALL be synchronous-safe: the first accepted beat is the first edge after reset_ni rises with wr_valid_i high.

Verification
REQ-044 Load slot 2 with words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF back-to-back, then rd_slot_i=2 -> COMMIT 4 edges after the first beat; key_o=0x00112233445566778899AABBCCDDEEFF and key_valid_o=1 one cycle later; slots 0, 1 and 3 still invalid.
REQ-045 Same load with wr_valid_i low for 3 cycles between beats 1 and 2 -> identical result; busy_o high throughout the gap.
REQ-046 lock_i on slot 1 during beat 2 of a load to slot 1 holding 0xA5...A5 -> err_o pulses for one cycle in COMMIT; slot 1 keeps 0xA5...A5.
REQ-047 abort_i after 2 beats, then a full 4-beat load to slot 0 -> slot 0 holds only the new key, with no words from the aborted load.
REQ-048 Assert clear_i during COMMIT and, on another run, reset_ni low mid-load -> all slots invalid, key_o=0, locks cleared, wr_ready_o=1 afterwards.
